// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the register-dump sequencer state encoding,
// used by the decode-stage register file and the debug unit.
package pipeline_pkg;

    localparam int DEF_NB     = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_seq.sv
// Register dump sequencer: walks every register over a valid/ready stream,
// fetching each word live through a single read-port view of the array.
module regfile_dump_seq
    import pipeline_pkg::*;
#(
    parameter int NB     = DEF_NB,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [NB-1:0]     i_rd_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [NB-1:0]     o_data,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    dump_state_t       state_r, state_nx_s;
    logic [ADDR_W-1:0] addr_r, addr_nx_s;
    logic [NB-1:0]     data_r, data_nx_s;
    logic              valid_r, last_r, busy_r, done_r;

    // Read-port address: word 0 while idle, the next word while sending
    always_comb begin
        o_rd_addr = {ADDR_W{1'b0}};
        if (state_r == SEND) begin
            o_rd_addr = addr_r + ADDR_W'(1);
        end else begin
            o_rd_addr = {ADDR_W{1'b0}};
        end
    end

    // Next-state, address counter and data load
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        data_nx_s  = data_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_nx_s = SEND;
                    addr_nx_s  = {ADDR_W{1'b0}};
                    data_nx_s  = i_rd_data;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                if (i_ready && (addr_r == LAST_ADDR)) begin
                    state_nx_s = DONE;
                end else if (i_ready) begin
                    addr_nx_s = addr_r + ADDR_W'(1);
                    data_nx_s = i_rd_data;
                end else begin
                    state_nx_s = SEND;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State and flags registered together so every output is a flop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {NB{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            data_r  <= data_nx_s;
            valid_r <= (state_nx_s == SEND);
            last_r  <= (state_nx_s == SEND) && (addr_nx_s == LAST_ADDR);
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == DONE);
        end
    end

    assign o_valid = valid_r;
    assign o_addr  = addr_r;
    assign o_data  = data_r;
    assign o_last  = last_r;
    assign o_busy  = busy_r;
    assign o_done  = done_r;

endmodule

// File: rtl/regfile_dump_bank.sv
// Decode-stage register file with N read ports, debug peek and dump streamer.
// Optional same-cycle write-through on reads: define REGFILE_WB_BYPASS_EN.
module regfile_dump_bank
    import pipeline_pkg::*;
#(
    parameter int NB      = DEF_NB,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NREGS   = DEF_NREGS,
    parameter int NRD     = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_step,
    input  logic                  i_wb_we,
    input  logic [ADDR_W-1:0]     i_wb_addr,
    input  logic [NB-1:0]         i_wb_data,
    input  logic [NRD*ADDR_W-1:0] i_rd_addr,
    output logic [NRD*NB-1:0]     o_rd_data,
    input  logic [ADDR_W-1:0]     i_dbg_addr,
    output logic [NB-1:0]         o_dbg_data,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [ADDR_W-1:0]     o_dump_addr,
    output logic [NB-1:0]         o_dump_data,
    output logic                  o_dump_last,
    output logic                  o_dump_busy,
    output logic                  o_dump_done
);

    localparam logic [ADDR_W:0] NREGS_C = (ADDR_W + 1)'(NREGS);

    logic [NB-1:0]     mem_r [NREGS];
    logic              wr_en_s;
    logic [ADDR_W-1:0] seq_rd_addr_s;
    logic [NB-1:0]     seq_rd_data_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREGS_C);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (R0_ZERO != 0) && (a == {ADDR_W{1'b0}});
    endfunction

    // wr_en_s already excludes r0, so the bypass can never leak a write to it
    function automatic logic [NB-1:0] rd_word(input logic [ADDR_W-1:0] a);
        logic [NB-1:0] w;
        if (!in_range(a) || is_zero_reg(a)) begin
            w = {NB{1'b0}};
`ifdef REGFILE_WB_BYPASS_EN
        end else if (wr_en_s && (a == i_wb_addr)) begin
            w = i_wb_data;
`endif
        end else begin
            w = mem_r[a];
        end
        return w;
    endfunction

    // Write-back qualifier: pipeline step, enable, legal and writable target
    always_comb begin
        wr_en_s = i_step && i_wb_we && in_range(i_wb_addr) && !is_zero_reg(i_wb_addr);
    end

    // Register array
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {NB{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[i_wb_addr] <= i_wb_data;
        end else begin
            mem_r[0] <= mem_r[0];
        end
    end

    // Pipeline read ports
    always_comb begin
        o_rd_data = {(NRD*NB){1'b0}};
        for (int k = 0; k < NRD; k++) begin
            o_rd_data[k*NB +: NB] = rd_word(i_rd_addr[k*ADDR_W +: ADDR_W]);
        end
    end

    // Debug peek and the sequencer's read view
    always_comb begin
        o_dbg_data    = rd_word(i_dbg_addr);
        seq_rd_data_s = rd_word(seq_rd_addr_s);
    end

    regfile_dump_seq #(
        .NB     (NB),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_dump_seq (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_dump_start),
        .i_ready   (i_dump_ready),
        .o_rd_addr (seq_rd_addr_s),
        .i_rd_data (seq_rd_data_s),
        .o_valid   (o_dump_valid),
        .o_addr    (o_dump_addr),
        .o_data    (o_dump_data),
        .o_last    (o_dump_last),
        .o_busy    (o_dump_busy),
        .o_done    (o_dump_done)
    );

endmodule
